arb_mux: RTL and testbench

ARB_MUX -- requirements
Module: arb_mux

---
 rtl/arb_mux_if.sv | 36 +++
 rtl/arb_mux.sv | 109 ++++++++++
 tb/tb_arb_mux.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/arb_mux_if.sv
// Channel-input and result-output bundle for arb_mux; GrantCount exists only when ARB_MUX_COUNT_EN is defined.
interface arb_mux_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int SELW = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] InData;
  logic [CHANNELS-1:0]       InValid;
  logic [CHANNELS-1:0]       InReady;
  logic                      Mode;
  logic [SELW-1:0]           Select;
  logic [WIDTH-1:0]          Result;
  logic                      ResultValid;
  logic                      ResultReady;
  logic [SELW-1:0]           ResultChannel;
`ifdef ARB_MUX_COUNT_EN
  logic [15:0]               GrantCount;
`endif

  modport slave (
    input  InData, InValid, Mode, Select, ResultReady,
    output InReady, Result, ResultValid, ResultChannel
`ifdef ARB_MUX_COUNT_EN
    , output GrantCount
`endif
  );

  modport master (
    output InData, InValid, Mode, Select, ResultReady,
    input  InReady, Result, ResultValid, ResultChannel
`ifdef ARB_MUX_COUNT_EN
    , input GrantCount
`endif
  );
endinterface

// File: rtl/arb_mux.sv
// N-channel to 1 arbitrating mux with a one-word output register (fixed select or round-robin).
// States: EMPTY | no word held ; FULL | Result holds a word. Macro ARB_MUX_COUNT_EN adds GrantCount.
module arb_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic     Clk,
  input  logic     nReset,
  arb_mux_if.slave bus
);
  localparam int SELW = $clog2(CHANNELS);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WIDTH-1:0]    r_result;
  logic [SELW-1:0]     r_channel;
  logic [SELW-1:0]     r_last;

  logic                w_grant_vld;
  logic [SELW-1:0]     w_grant_idx;
  logic [SELW-1:0]     w_rr_idx;
  logic                w_can_accept;
  logic [CHANNELS-1:0] w_in_ready;
  logic                w_in_xfer;
  logic                w_out_xfer;

  // Grant decision: round-robin scans upward from the channel after the last winner.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_rr_idx    = '0;
    if (bus.Mode == 1'b0) begin
      if ((int'(bus.Select) < CHANNELS) && bus.InValid[bus.Select]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = bus.Select;
      end
    end else begin
      for (int k = 1; k <= CHANNELS; k++) begin
        w_rr_idx = SELW'((int'(r_last) + k) % CHANNELS);
        if (!w_grant_vld && bus.InValid[w_rr_idx]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = w_rr_idx;
        end
      end
    end
  end

  assign w_can_accept = (r_state == S_EMPTY) || bus.ResultReady;

  always_comb begin
    w_in_ready = '0;
    if (nReset && w_can_accept && w_grant_vld) begin
      w_in_ready[w_grant_idx] = 1'b1;
    end
  end

  assign w_in_xfer  = |(w_in_ready & bus.InValid);
  assign w_out_xfer = (r_state == S_FULL) && bus.ResultReady;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_in_xfer) w_state_nxt = S_FULL;
      S_FULL:  if (w_out_xfer && !w_in_xfer) w_state_nxt = S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_result  <= '0;
      r_channel <= '0;
      r_last    <= SELW'(CHANNELS - 1);
    end else if (w_in_xfer) begin
      r_result  <= bus.InData[int'(w_grant_idx)*WIDTH +: WIDTH];
      r_channel <= w_grant_idx;
      r_last    <= w_grant_idx;
    end
  end

`ifdef ARB_MUX_COUNT_EN
  logic [15:0] r_grant_count;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_grant_count <= '0;
    end else if (w_in_xfer && (r_grant_count != 16'hFFFF)) begin
      r_grant_count <= r_grant_count + 16'd1;
    end
  end

  assign bus.GrantCount = r_grant_count;
`endif

  assign bus.InReady       = w_in_ready;
  assign bus.Result        = r_result;
  assign bus.ResultValid   = (r_state == S_FULL);
  assign bus.ResultChannel = r_channel;
endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux: directed steps plus random traffic against a behavioural model.
module tb_arb_mux;
  localparam int W   = 8;
  localparam int CH  = 4;
  localparam int CH3 = 3;

  logic Clk    = 1'b0;
  logic nReset = 1'b0;
  always #5 Clk = ~Clk;

  arb_mux_if #(.WIDTH(W), .CHANNELS(CH))  bus ();
  arb_mux_if #(.WIDTH(W), .CHANNELS(CH3)) bus3 ();

  arb_mux #(.WIDTH(W), .CHANNELS(CH))  dut  (.Clk(Clk), .nReset(nReset), .bus(bus));
  arb_mux #(.WIDTH(W), .CHANNELS(CH3)) dut3 (.Clk(Clk), .nReset(nReset), .bus(bus3));

  int n_cmp = 0;
  int n_mis = 0;

  // Behavioural model: one holding slot plus the last winner and a saturating grant count.
  bit         m_full;
  logic [7:0] m_data;
  int         m_ch;
  int         m_last;
  int         m_cnt;

  int rr_all[5]  = '{0, 1, 2, 3, 0};
  int rr_odd[3]  = '{1, 3, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_grant();
    logic [CH-1:0] v;
    int c;
    v = bus.InValid;
    if (bus.Mode == 1'b0) begin
      if ((int'(bus.Select) < CH) && v[bus.Select]) return int'(bus.Select);
      return -1;
    end
    for (int k = 1; k <= CH; k++) begin
      c = (m_last + k) % CH;
      if (v[c[1:0]]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_full = 1'b0;
    m_data = '0;
    m_ch   = 0;
    m_last = CH - 1;
    m_cnt  = 0;
  endtask

  task automatic drive(input logic mode, input logic [1:0] sel, input logic [3:0] valid,
                       input logic [31:0] data, input logic rready);
    bus.Mode        = mode;
    bus.Select      = sel;
    bus.InValid     = valid;
    bus.InData      = data;
    bus.ResultReady = rready;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step();
    int g;
    logic [CH-1:0] er;
    #1;
    g  = ref_grant();
    er = '0;
    if (g >= 0 && (!m_full || bus.ResultReady)) er[g[1:0]] = 1'b1;
    chk("in_ready", {28'd0, bus.InReady}, {28'd0, er});
    @(posedge Clk);
    if (er != '0) begin
      m_full = 1'b1;
      m_data = bus.InData[g*W +: W];
      m_ch   = g;
      m_last = g;
      if (m_cnt < 65535) m_cnt++;
    end else if (m_full && bus.ResultReady) begin
      m_full = 1'b0;
    end
    #1;
    chk("result_valid", {31'd0, bus.ResultValid}, {31'd0, m_full});
    if (m_full) begin
      chk("result", {24'd0, bus.Result}, {24'd0, m_data});
      chk("result_ch", {30'd0, bus.ResultChannel}, m_ch);
    end
`ifdef ARB_MUX_COUNT_EN
    chk("grant_count", {16'd0, bus.GrantCount}, m_cnt);
`endif
    @(negedge Clk);
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    #1;
    chk("rst_in_ready", {28'd0, bus.InReady}, 32'd0);
    chk("rst_valid", {31'd0, bus.ResultValid}, 32'd0);
    chk("rst_result", {24'd0, bus.Result}, 32'd0);
    chk("rst_ch", {30'd0, bus.ResultChannel}, 32'd0);
    @(negedge Clk);
    bus.InValid = '0;
    nReset = 1'b1;
    model_reset();
    #1;
    chk("post_rst_valid", {31'd0, bus.ResultValid}, 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    model_reset();
    drive(1'b1, 2'd0, 4'hF, 32'h0, 1'b1);
    bus3.Mode        = 1'b0;
    bus3.Select      = 2'd3;
    bus3.InValid     = 3'b111;
    bus3.InData      = 24'h123456;
    bus3.ResultReady = 1'b1;
    @(negedge Clk);

    // Reset with every channel requesting
    bus.InValid = 4'hF;
    do_reset();
    chk("post_rst_result", {24'd0, bus.Result}, 32'd0);
    chk("post_rst_ch", {30'd0, bus.ResultChannel}, 32'd0);

    // Fixed select, sustained one word per cycle
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      if (i == 0) d[23:16] = 8'hA5;
      drive(1'b0, 2'd2, 4'hF, d, 1'b1);
      step();
      if (i == 0) begin
        chk("fixed_result", {24'd0, bus.Result}, 32'h0000_00A5);
        chk("fixed_ch", {30'd0, bus.ResultChannel}, 32'd2);
      end
    end

    // Round-robin from reset, all valid, then only ch1/ch3
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'd0, 4'hF, $urandom, 1'b1);
      step();
      chk("rr_all_seq", {30'd0, bus.ResultChannel}, rr_all[i]);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd0, 4'b1010, $urandom, 1'b1);
      step();
      chk("rr_odd_seq", {30'd0, bus.ResultChannel}, rr_odd[i]);
    end

    // Backpressure: hold 3C from ch1, then drain and refill in one cycle
    drive(1'b0, 2'd0, 4'b0000, 32'h0, 1'b1);
    step();
    drive(1'b0, 2'd1, 4'b0010, 32'h0000_3C00, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1'($urandom), 2'($urandom), 4'($urandom), $urandom, 1'b0);
      step();
      chk("hold_result", {24'd0, bus.Result}, 32'h0000_003C);
      chk("hold_ch", {30'd0, bus.ResultChannel}, 32'd1);
    end
    drive(1'b0, 2'd0, 4'b0001, 32'h0000_0077, 1'b1);
    step();
    chk("refill_valid", {31'd0, bus.ResultValid}, 32'd1);
    chk("refill_result", {24'd0, bus.Result}, 32'h0000_0077);
    drive(1'b0, 2'd0, 4'b0000, 32'h0, 1'b0);
    step();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom), 2'($urandom), 4'($urandom), $urandom, ($urandom_range(0, 3) != 0));
      step();
    end

    // Out-of-range Select on a 3-channel instance, then an in-range one
    #1;
    chk("sel_oob_ready", {29'd0, bus3.InReady}, 32'd0);
    @(posedge Clk); #1;
    chk("sel_oob_valid", {31'd0, bus3.ResultValid}, 32'd0);
    @(negedge Clk);
    bus3.Select = 2'd1;
    #1;
    chk("sel_inrange_ready", {29'd0, bus3.InReady}, 32'd2);
    @(posedge Clk); #1;
    chk("sel_inrange_valid", {31'd0, bus3.ResultValid}, 32'd1);
    @(negedge Clk);

    // Reset asserted while FULL
    drive(1'b0, 2'd0, 4'b0001, 32'h0000_00C3, 1'b0);
    step();
    #2;
    nReset = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, bus.ResultValid}, 32'd0);
    chk("midrst_result", {24'd0, bus.Result}, 32'd0);
    chk("midrst_ready", {28'd0, bus.InReady}, 32'd0);
    model_reset();
    @(negedge Clk);
    bus.InValid = '0;
    nReset = 1'b1;
    step();

`ifdef ARB_MUX_COUNT_EN
    do_reset();
    drive(1'b0, 2'd0, 4'b0001, 32'h0000_005A, 1'b1);
    repeat (65540) @(negedge Clk);
    m_full = 1'b1; m_data = 8'h5A; m_ch = 0; m_last = 0; m_cnt = 65535;
    #1;
    chk("count_sat", {16'd0, bus.GrantCount}, 32'h0000_FFFF);
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
